// File: rtl/mesm6_alu_seq_pkg.sv
// Types and constants shared by the MESM-6 ALU issue sequencer and its watchdog.
// Opcode values come from the shared MESM-6 defines and are re-exported here
// as typed localparams.
`ifndef MESM6_DEFINES_SV
`include "mesm6_defines.sv"
`endif

package mesm6_alu_seq_pkg;

  localparam int OP_WIDTH   = `ALU_OP_WIDTH;
  localparam int WORD_WIDTH = 48;

  typedef logic [OP_WIDTH-1:0]   alu_op_t;
  typedef logic [WORD_WIDTH-1:0] word_t;

  localparam alu_op_t OP_NOP    = `ALU_NOP;
  localparam alu_op_t OP_AND    = `ALU_AND;
  localparam alu_op_t OP_OR     = `ALU_OR;
  localparam alu_op_t OP_XOR    = `ALU_XOR;
  localparam alu_op_t OP_ADD_CA = `ALU_ADD_CARRY_AROUND;
  localparam alu_op_t OP_YTA    = `ALU_YTA;
  localparam alu_op_t OP_FADD   = `ALU_FADD;
  localparam alu_op_t OP_FDIV   = `ALU_FDIV;

  // Y := A is only meaningful on a NOP; any other op drops the request.
  function automatic logic wy_effective(input alu_op_t op, input logic wy);
    return wy && (op == OP_NOP);
  endfunction

endpackage

// File: rtl/mesm6_alu_watchdog.sv
// Watchdog for the ALU issue sequencer: synchronous clear, count enable and a
// terminal-count flag raised at TIMEOUT_CYCLES-1. The count parks at the
// terminal value instead of wrapping.
module mesm6_alu_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // Cycle counter: clear wins over increment, holds at the terminal value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !tc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/mesm6_defines.sv
// Shared MESM-6 ALU definitions: operation-code width and opcode values.
`ifndef MESM6_DEFINES_SV
`define MESM6_DEFINES_SV

`define ALU_OP_WIDTH          5

`define ALU_NOP               5'd0
`define ALU_AND               5'd1
`define ALU_OR                5'd2
`define ALU_XOR               5'd3
`define ALU_ADD_CARRY_AROUND  5'd4
`define ALU_YTA               5'd5
`define ALU_FADD              5'd6
`define ALU_FDIV              5'd7

`endif

// File: rtl/mesm6_alu_seq.sv
// MESM-6 ALU issue sequencer. Accepts one request at a time, drives and holds
// the ALU inputs until done, enforces a NOP cycle between operations, returns
// the result over a valid/ready handshake and aborts hung operations.
// Optional statistics counters: define MESM6_ALU_SEQ_STATS_EN.
module mesm6_alu_seq
  import mesm6_alu_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
`ifdef MESM6_ALU_SEQ_STATS_EN
  , parameter int CNT_WIDTH = 32
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [OP_WIDTH-1:0]   req_op,
  input  logic [WORD_WIDTH-1:0] req_a,
  input  logic [WORD_WIDTH-1:0] req_b,
  input  logic                  req_wy,
  input  logic                  req_log,
  input  logic                  req_norm,
  input  logic                  req_round,
  output logic [OP_WIDTH-1:0]   alu_op,
  output logic                  alu_wy,
  output logic                  alu_grp_log,
  output logic                  alu_do_norm,
  output logic                  alu_do_round,
  output logic [WORD_WIDTH-1:0] alu_a,
  output logic [WORD_WIDTH-1:0] alu_b,
  input  logic [WORD_WIDTH-1:0] alu_acc,
  input  logic                  alu_done,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WORD_WIDTH-1:0] rsp_acc,
  output logic                  rsp_err
`ifdef MESM6_ALU_SEQ_STATS_EN
  , output logic [CNT_WIDTH-1:0] stat_ops
  , output logic [CNT_WIDTH-1:0] stat_busy
  , output logic [CNT_WIDTH-1:0] stat_timeouts
`endif
);

  typedef enum logic [1:0] {IDLE, WY, ISSUE, RESP} state_t;

  state_t state;
  logic   req_fire;
  logic   rsp_fire;
  logic   wd_tc;
  logic   abort;

  assign req_fire = (state == IDLE) && req_valid && req_ready;
  assign rsp_fire = (state == RESP) && rsp_ready;
  // Done has priority over the watchdog when both land in the same cycle.
  assign abort    = (state == ISSUE) && !alu_done && wd_tc;

  mesm6_alu_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (req_fire),
    .inc    (state == ISSUE),
    .tc     (wd_tc)
  );

  // Sequencer FSM with all ALU-side and response-side outputs registered.
  // NOTE: sequential state uses non-blocking assignments so every register
  // in this block samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      req_ready    <= 1'b0;
      alu_op       <= OP_NOP;
      alu_wy       <= 1'b0;
      alu_grp_log  <= 1'b0;
      alu_do_norm  <= 1'b0;
      alu_do_round <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      rsp_valid    <= 1'b0;
      rsp_acc      <= '0;
      rsp_err      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_fire) begin
            alu_op       <= req_op;
            alu_wy       <= wy_effective(req_op, req_wy);
            alu_grp_log  <= req_log;
            alu_do_norm  <= req_norm;
            alu_do_round <= req_round;
            alu_a        <= req_a;
            alu_b        <= req_b;
            req_ready    <= 1'b0;
            state        <= (req_op == OP_NOP) ? WY : ISSUE;
          end else begin
            // Registered so the ALU always sees a NOP edge before the first op.
            req_ready <= !rsp_valid;
          end
        end
        WY: begin
          alu_wy    <= 1'b0;
          rsp_acc   <= alu_acc;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        ISSUE: begin
          if (alu_done) begin
            rsp_acc   <= alu_acc;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            alu_op    <= OP_NOP;
            state     <= RESP;
          end else if (abort) begin
            rsp_acc   <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            alu_op    <= OP_NOP;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MESM6_ALU_SEQ_STATS_EN
  // Saturating statistics: completed handshakes, busy cycles, watchdog aborts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_ops      <= '0;
      stat_busy     <= '0;
      stat_timeouts <= '0;
    end else begin
      if (rsp_fire && (stat_ops != '1)) begin
        stat_ops <= stat_ops + 1'b1;
      end
      if (((state == ISSUE) || (state == WY)) && (stat_busy != '1)) begin
        stat_busy <= stat_busy + 1'b1;
      end
      if (abort && (stat_timeouts != '1)) begin
        stat_timeouts <= stat_timeouts + 1'b1;
      end
    end
  end
`else
  // Handshake term only feeds the statistics counters.
  logic unused_rsp_fire;
  assign unused_rsp_fire = rsp_fire;
`endif

endmodule

// File: tb/tb_mesm6_alu_seq.sv
// Directed, scoreboard-based bench for the MESM-6 ALU issue sequencer, with a
// behavioural ALU stub (fixed per-op latency, Y register, optional hang).
module tb_mesm6_alu_seq;
  import mesm6_alu_seq_pkg::*;

  localparam int TIMEOUT = 16;

  logic    clk = 1'b0;
  logic    reset_n = 1'b0;
  logic    req_valid = 1'b0;
  logic    req_ready;
  alu_op_t req_op = OP_NOP;
  word_t   req_a = '0;
  word_t   req_b = '0;
  logic    req_wy = 1'b0;
  logic    req_log = 1'b0;
  logic    req_norm = 1'b0;
  logic    req_round = 1'b0;
  alu_op_t alu_op;
  logic    alu_wy, alu_grp_log, alu_do_norm, alu_do_round;
  word_t   alu_a, alu_b, alu_acc;
  logic    alu_done;
  logic    rsp_valid;
  logic    rsp_ready = 1'b0;
  word_t   rsp_acc;
  logic    rsp_err;
`ifdef MESM6_ALU_SEQ_STATS_EN
  logic [31:0] stat_ops, stat_busy, stat_timeouts;
`endif

  mesm6_alu_seq #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_wy(req_wy), .req_log(req_log),
    .req_norm(req_norm), .req_round(req_round),
    .alu_op(alu_op), .alu_wy(alu_wy), .alu_grp_log(alu_grp_log),
    .alu_do_norm(alu_do_norm), .alu_do_round(alu_do_round),
    .alu_a(alu_a), .alu_b(alu_b), .alu_acc(alu_acc), .alu_done(alu_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_acc(rsp_acc),
    .rsp_err(rsp_err)
`ifdef MESM6_ALU_SEQ_STATS_EN
    , .stat_ops(stat_ops), .stat_busy(stat_busy), .stat_timeouts(stat_timeouts)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- ALU stub ----------------
  logic  hang = 1'b0;
  word_t y_reg, res_q;
  logic  done_q;
  int    lat_cnt;

  function automatic int op_latency(input alu_op_t op);
    case (op)
      OP_ADD_CA: return 2;
      OP_FADD:   return 3;
      OP_FDIV:   return 12;
      default:   return 1;
    endcase
  endfunction

  function automatic word_t op_result(input alu_op_t op, input word_t a, input word_t b, input word_t y);
    logic [WORD_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      OP_AND:    return a & b;
      OP_OR:     return a | b;
      OP_XOR:    return a ^ b;
      OP_ADD_CA: return s[WORD_WIDTH-1:0] + word_t'(s[WORD_WIDTH]);
      OP_YTA:    return y;
      default:   return a;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= 1'b0; lat_cnt <= 0; y_reg <= '0; res_q <= '0;
    end else if (alu_op == OP_NOP) begin
      done_q <= 1'b0; lat_cnt <= 0;
      if (alu_wy) y_reg <= alu_a;
    end else if (!done_q && !hang) begin
      if (lat_cnt + 1 >= op_latency(alu_op)) begin
        done_q <= 1'b1;
        res_q  <= op_result(alu_op, alu_a, alu_b, y_reg);
      end
      lat_cnt <= lat_cnt + 1;
    end
  end

  assign alu_done = done_q;
  assign alu_acc  = (alu_op == OP_NOP) ? alu_a : res_q;

  // ---------------- scoreboard and checking ----------------
  typedef struct { word_t acc; logic err; } exp_t;
  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   accept_cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input alu_op_t op, input word_t a, input word_t b,
                           input logic wy, input logic lg, input word_t e_acc, input logic e_err);
    exp_t e;
    req_op = op; req_a = a; req_b = b; req_wy = wy; req_log = lg;
    req_norm = 1'b0; req_round = 1'b0; req_valid = 1'b1;
    e.acc = e_acc; e.err = e_err;
    sb.push_back(e);
  endtask

  task automatic accept(input string tag);
    int n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    check({tag, ".req_ready"}, 64'(req_ready), 64'd1);
    tick();
    accept_cyc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic send(input string tag, input alu_op_t op, input word_t a, input word_t b,
                      input logic wy, input logic lg, input word_t e_acc, input logic e_err);
    drive_req(op, a, b, wy, lg, e_acc, e_err);
    accept(tag);
  endtask

  task automatic wait_rsp(input string tag, input int exp_edges);
    int n = 0;
    exp_t e;
    while (!rsp_valid && n < 40) begin tick(); n++; end
    check({tag, ".latency"}, 64'(cyc - accept_cyc), 64'(exp_edges));
    check({tag, ".sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".acc"}, 64'(rsp_acc), 64'(e.acc));
      check({tag, ".err"}, 64'(rsp_err), 64'(e.err));
    end
  endtask

  task automatic take_rsp(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, ".valid_drop"}, 64'(rsp_valid), 64'd0);
    check({tag, ".ready_rise"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    // Reset values
    #1;
    check("rst.alu_op", 64'(alu_op), 64'(OP_NOP));
    check("rst.req_ready", 64'(req_ready), 64'd0);
    check("rst.rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst.rsp_acc", 64'(rsp_acc), 64'd0);
    check("rst.rsp_err", 64'(rsp_err), 64'd0);
    check("rst.alu_a", 64'(alu_a), 64'd0);
    tick(); tick();
    reset_n = 1'b1;
    check("rel.req_ready_low", 64'(req_ready), 64'd0);
    tick();
    check("rel.req_ready_high", 64'(req_ready), 64'd1);

    // AND: single-cycle op, response two edges after accept
    send("and", OP_AND, 48'hFFFF_0000_FFFF, 48'h0F0F_0F0F_0F0F, 1'b0, 1'b0, 48'h0F0F_0000_0F0F, 1'b0);
    check("and.alu_op", 64'(alu_op), 64'(OP_AND));
    check("and.req_ready_busy", 64'(req_ready), 64'd0);
    wait_rsp("and", 2);
    take_rsp("and");

    // Carry-around add: two-cycle op; alu_op back to NOP after done
    send("addca", OP_ADD_CA, 48'hFFFF_FFFF_FFFF, 48'h1, 1'b0, 1'b0, 48'h1, 1'b0);
    wait_rsp("addca", 3);
    check("addca.alu_op_nop", 64'(alu_op), 64'(OP_NOP));
    take_rsp("addca");

    // Back-to-back AND then OR with a stalled consumer
    send("b2b_and", OP_AND, 48'h0000_FFFF_00FF, 48'h1234_5678_9ABC, 1'b0, 1'b0, 48'h0000_5678_00BC, 1'b0);
    wait_rsp("b2b_and", 2);
    drive_req(OP_OR, 48'h0000_FFFF_00FF, 48'h1234_5678_9ABC, 1'b0, 1'b0, 48'h1234_FFFF_9AFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("b2b.stall_acc", 64'(rsp_acc), 64'h0000_5678_00BC);
      check("b2b.stall_valid", 64'(rsp_valid), 64'd1);
      check("b2b.stall_req_ready", 64'(req_ready), 64'd0);
      check("b2b.stall_alu_nop", 64'(alu_op), 64'(OP_NOP));
    end
    take_rsp("b2b_and");
    accept("b2b_or");
    check("b2b_or.alu_op", 64'(alu_op), 64'(OP_OR));
    wait_rsp("b2b_or", 2);
    take_rsp("b2b_or");

    // Illegal wy with a non-NOP op is dropped
    send("illwy", OP_XOR, 48'hFF, 48'h0F, 1'b1, 1'b0, 48'hF0, 1'b0);
    check("illwy.alu_wy", 64'(alu_wy), 64'd0);
    wait_rsp("illwy", 2);
    take_rsp("illwy");

    // Watchdog abort with a hung ALU, then a normal op
    hang = 1'b1;
    send("tmo", OP_FADD, 48'h1, 48'h2, 1'b0, 1'b0, 48'h0, 1'b1);
    wait_rsp("tmo", TIMEOUT);
    check("tmo.alu_op_nop", 64'(alu_op), 64'(OP_NOP));
    take_rsp("tmo");
    hang = 1'b0;
    send("post_tmo", OP_OR, 48'hA000_0000_0000, 48'h5, 1'b0, 1'b0, 48'hA000_0000_0005, 1'b0);
    wait_rsp("post_tmo", 2);
    take_rsp("post_tmo");

    // Y := A on NOP, then YTA reads it back
    send("wy", OP_NOP, 48'h1234_5678_9ABC, 48'h0, 1'b1, 1'b0, 48'h1234_5678_9ABC, 1'b0);
    check("wy.alu_wy", 64'(alu_wy), 64'd1);
    wait_rsp("wy", 1);
    check("wy.alu_wy_clear", 64'(alu_wy), 64'd0);
    take_rsp("wy");
    send("yta", OP_YTA, 48'h0, 48'h0, 1'b0, 1'b1, 48'h1234_5678_9ABC, 1'b0);
    check("yta.grp_log", 64'(alu_grp_log), 64'd1);
    wait_rsp("yta", 2);
    take_rsp("yta");

    // Asynchronous reset in the middle of a long FDIV
    send("fdiv", OP_FDIV, 48'h7, 48'h3, 1'b0, 1'b0, 48'h0, 1'b0);
    tick(); tick(); tick();
    check("fdiv.busy_op", 64'(alu_op), 64'(OP_FDIV));
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst.alu_op", 64'(alu_op), 64'(OP_NOP));
    check("mid_rst.rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst.req_ready", 64'(req_ready), 64'd0);
    sb.delete();
    tick();
    reset_n = 1'b1;
    check("mid_rel.req_ready_low", 64'(req_ready), 64'd0);
    tick();
    check("mid_rel.req_ready_high", 64'(req_ready), 64'd1);
    send("xor", OP_XOR, 48'h5, 48'h3, 1'b0, 1'b0, 48'h6, 1'b0);
    wait_rsp("xor", 2);
    take_rsp("xor");

    check("sb.drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mesm6_alu_seq.md
Name: mesm6_alu_seq

Overview:
Issue sequencer sitting directly upstream of the MESM-6 ALU.
- Accepts one arithmetic request at a time from the instruction pipeline over a valid/ready handshake.
- Drives the ALU op, mode and operand inputs and holds them stable until the ALU raises done.
- Forces the mandatory ALU_NOP cycle between operations, captures the result, and returns it downstream over a second valid/ready handshake.
- A watchdog aborts any operation that never completes.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in ISSUE before abort. Must be at least 2 and must cover the worst-case FADD shift-align plus post-normalisation.
CNT_WIDTH, 32, width of statistics counters; used only with the optional feature.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_op  in  ALU_OP_WIDTH  ALU operation code
req_a  in  48  operand A (accumulator)
req_b  in  48  operand B
req_wy  in  1  Y := A; legal only with ALU_NOP
req_log  in  1  logical group
req_norm  in  1  normalisation enabled
req_round  in  1  rounding enabled
alu_op  out  ALU_OP_WIDTH  to ALU op
alu_wy  out  1  to ALU wy
alu_grp_log  out  1  to ALU grp_log
alu_do_norm  out  1  to ALU do_norm
alu_do_round  out  1  to ALU do_round
alu_a  out  48  to ALU a
alu_b  out  48  to ALU b
alu_acc  in  48  ALU result
alu_done  in  1  ALU finished
rsp_valid  out  1  result present
rsp_ready  in  1  consumer takes result
rsp_acc  out  48  captured result
rsp_err  out  1  operation aborted by watchdog

Behaviour:
Reset (asynchronous, reset_n low):
- state=IDLE; alu_op=ALU_NOP; alu_wy, alu_grp_log, alu_do_norm, alu_do_round=0; alu_a, alu_b=0.
- rsp_valid=0, rsp_acc=0, rsp_err=0, req_ready=0, watchdog=0.

States:
- IDLE:
  - alu_op=ALU_NOP; req_ready = !rsp_valid. req_ready is registered, so it first rises on the first clk edge after reset release; this guarantees the ALU has seen at least one NOP edge.
  - On req_valid && req_ready: register all req_* into the alu_* outputs; clear the watchdog; go to ISSUE (or WY if req_op==ALU_NOP).
- WY:
  - One cycle with alu_op=ALU_NOP, alu_wy=1.
  - Next edge: alu_wy<=0, rsp_acc<=alu_acc, rsp_err<=0, rsp_valid<=1; go to RESP.
- ISSUE:
  - alu_* outputs held constant; req_ready=0; watchdog increments each cycle.
  - alu_done=1: rsp_acc<=alu_acc, rsp_err<=0, rsp_valid<=1, alu_op<=ALU_NOP; go to RESP.
  - Watchdog reaches TIMEOUT_CYCLES-1 with alu_done=0: rsp_acc<=0, rsp_err<=1, rsp_valid<=1, alu_op<=ALU_NOP; go to RESP.
  - alu_done and timeout in the same cycle: done wins.
- RESP:
  - alu_op=ALU_NOP, so the ALU clears done.
  - rsp_* held stable while rsp_ready=0.
  - On rsp_ready: rsp_valid<=0; go to IDLE. req_ready rises on the same edge.
- alu_done is ignored outside ISSUE.

Latency:
- For an ALU op taking N cycles to done, rsp_valid rises N+1 edges after the accepting edge.
- Minimum request-to-request spacing is 3 cycles (IDLE, ISSUE, RESP with rsp_ready=1).

Reset mid-operation: all outputs go to reset values immediately; any in-flight result is discarded.

Illegal input: req_wy=1 with an op other than NOP is treated as wy=0.

Optional Feature:
MESM6_ALU_SEQ_STATS_EN
- Defined:
  - Adds outputs stat_ops [CNT_WIDTH], incremented on each response handshake.
  - Adds stat_busy [CNT_WIDTH], incremented every cycle in ISSUE or WY.
  - Adds stat_timeouts [CNT_WIDTH], incremented on each watchdog abort.
  - All three saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared mesm6_defines.sv supplies ALU_OP_WIDTH and the ALU_* opcode macros; no new opcodes are added.
- The sequencer state enum (IDLE, WY, ISSUE, RESP) is local to the module.
- One natural sub-module: mesm6_alu_watchdog, a clear/increment/terminal-count counter, width $clog2(TIMEOUT_CYCLES).

Test Plan:
- ALU_AND, a=48'hFFFF_0000_FFFF, b=48'h0F0F_0F0F_0F0F, real mesm6_alu attached -> rsp_acc=48'h0F0F_0000_0F0F, rsp_err=0, rsp_valid 2 edges after accept.
- ALU_ADD_CARRY_AROUND, a=48'hFFFF_FFFF_FFFF, b=48'h1 -> rsp_acc=48'h1, rsp_valid 3 edges after accept; alu_op returns to NOP the cycle after done.
- Back-to-back AND then OR with rsp_ready held 0 for 5 cycles after the first result -> rsp_acc stable, req_ready=0 throughout, second op issued only after the handshake, and the ALU sees at least one NOP edge between the ops.
- Stub ALU with alu_done tied 0, TIMEOUT_CYCLES=16 -> rsp_valid=1, rsp_err=1, rsp_acc=0 exactly 16 edges after accept; next request completes normally.
- ALU_NOP with req_wy=1, a=48'h1234_5678_9ABC, followed by ALU_YTA with req_log=1 -> YTA rsp_acc=48'h1234_5678_9ABC.
- reset_n pulsed low mid ALU_FDIV -> alu_op=NOP and rsp_valid=0 asynchronously; req_ready=1 one edge after release; a following ALU_XOR (a=5, b=3) returns rsp_acc=6.
